// File: rtl/vec_fma_result_fifo.sv
// Result buffer behind the 3-lane vector FMA. Stores every vec3 result until
// the consumer takes it, and hands out issue credits so the FMA never needs
// to stall: an operand set is launched only when a slot is reserved for it.
module vec_fma_result_fifo #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         issue_fire,
  output logic                         issue_ok,
  input  logic [3*SIZE-1:0]            s_axis_result_tdata,
  input  logic                         s_axis_result_tvalid,
  output logic                         s_axis_result_tready,
  output logic [3*SIZE-1:0]            m_axis_result_tdata,
  output logic                         m_axis_result_tvalid,
  input  logic                         m_axis_result_tready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic                         err_overrun,
  output logic                         err_unexpected
);

  localparam int LANES = 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic          tready_q, tready_d;
  logic          issue_ok_q, issue_ok_d;
  logic          err_overrun_q, err_overrun_d;
  logic          err_unexpected_q, err_unexpected_d;
  logic [CW:0]   sum_d;
  logic          wr_en, rd_en, iss_en, credit_ret;

  // Event decode and next-state for pointers, counters, flow flags and errors.
  always_comb begin
    wr_en      = s_axis_result_tvalid & tready_q;
    rd_en      = (occ_q != '0) & m_axis_result_tready;
    iss_en     = issue_fire & issue_ok_q;
    // A result only returns a credit if one was actually outstanding.
    credit_ret = wr_en & (infl_q != '0);

    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    occ_d = occ_q;
    if (wr_en && !rd_en) begin
      occ_d = occ_q + CNT_ONE;
    end else if (rd_en && !wr_en) begin
      occ_d = occ_q - CNT_ONE;
    end

    infl_d = infl_q;
    if (iss_en && !credit_ret) begin
      infl_d = infl_q + CNT_ONE;
    end else if (credit_ret && !iss_en) begin
      infl_d = infl_q - CNT_ONE;
    end

    // One bit wider so stored+reserved can never wrap in the compare.
    sum_d      = {1'b0, occ_d} + {1'b0, infl_d};
    issue_ok_d = (sum_d < DEPTH_W);
    tready_d   = (occ_d != DEPTH_C);

    err_overrun_d    = err_overrun_q | (issue_fire & ~issue_ok_q);
    err_unexpected_d = err_unexpected_q |
                       (s_axis_result_tvalid & ((infl_q == '0) | (occ_q == DEPTH_C)));
  end

  // State registers; the flow flags stay low until the first edge after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      occ_q            <= '0;
      infl_q           <= '0;
      tready_q         <= 1'b0;
      issue_ok_q       <= 1'b0;
      err_overrun_q    <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
      infl_q           <= infl_d;
      tready_q         <= tready_d;
      issue_ok_q       <= issue_ok_d;
      err_overrun_q    <= err_overrun_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // One storage array per lane; the head is read straight from rd_ptr so it
  // falls through one cycle after the write and holds while not accepted.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [SIZE-1:0] lane_mem [DEPTH];

    // Lane write port; contents are not reset, the counters gate visibility.
    always_ff @(posedge aclk) begin
      if (wr_en) begin
        lane_mem[wr_ptr_q] <= s_axis_result_tdata[gi*SIZE +: SIZE];
      end
    end

    assign m_axis_result_tdata[gi*SIZE +: SIZE] = lane_mem[rd_ptr_q];
  end

  assign m_axis_result_tvalid = (occ_q != '0);
  assign s_axis_result_tready = tready_q;
  assign issue_ok             = issue_ok_q;
  assign occupancy            = occ_q;
  assign inflight             = infl_q;
  assign err_overrun          = err_overrun_q;
  assign err_unexpected       = err_unexpected_q;

endmodule
